// File: rtl/mem_fill_responder_if.sv
// ============================================================================
// Module   : mem_fill_responder_if
// Purpose  : Request/return bundle between the cache fill arbiter and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_fill_responder_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              enable;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic [ADDR_W-1:0] data_addr;
   logic              busy;

   modport master (
      output enable, wr, addr, data_in,
      input  data_out, data_valid, data_addr, busy
   );

   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, data_valid, data_addr, busy
   );
endinterface

`default_nettype wire

// File: rtl/mem_fill_responder.sv
// ============================================================================
// Module   : mem_fill_responder
// Purpose  : Fully pipelined word memory returning reads LATENCY cycles after
//            issue. Build option MEM_RDATA_HOLD_EN holds the last read result.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fill_responder #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int LATENCY = 4    // legal range 1..8
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   mem_fill_responder_if.slave  bus
);

   localparam int c_WORD_W = ADDR_W - 1;
   localparam int c_DEPTH  = 1 << c_WORD_W;

   logic [DATA_W-1:0]   r_mem  [c_DEPTH];
   logic [LATENCY-1:0]  r_vld;
   logic [c_WORD_W-1:0] r_addr [LATENCY];
   logic [DATA_W-1:0]   r_data [LATENCY];

   logic [c_WORD_W-1:0] w_idx;
   logic                w_wr_en;
   logic                w_rd_en;
   logic                w_unused;

   assign w_idx    = bus.addr[ADDR_W-1:1];
   assign w_wr_en  = bus.enable &  bus.wr;
   assign w_rd_en  = bus.enable & ~bus.wr;
   assign w_unused = bus.addr[0];

   // Array content survives reset; only the return pipeline is cleared.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[w_idx] <= bus.data_in;
      end
   end

   // Stage 0 snapshots the word at the issue edge, so a write in the
   // following cycle cannot alter a read already in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
         end
      end else begin
         r_vld[0]  <= w_rd_en;
         r_addr[0] <= w_idx;
         r_data[0] <= r_mem[w_idx];
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_addr[i] <= r_addr[i-1];
            r_data[i] <= r_data[i-1];
         end
      end
   end

   assign bus.data_valid = r_vld[LATENCY-1];
   assign bus.busy       = |r_vld;

`ifdef MEM_RDATA_HOLD_EN
   logic [DATA_W-1:0]   r_hold_data;
   logic [c_WORD_W-1:0] r_hold_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold_data <= '0;
         r_hold_addr <= '0;
      end else if (r_vld[LATENCY-1]) begin
         r_hold_data <= r_data[LATENCY-1];
         r_hold_addr <= r_addr[LATENCY-1];
      end
   end

   assign bus.data_out  = r_vld[LATENCY-1] ? r_data[LATENCY-1] : r_hold_data;
   assign bus.data_addr = r_vld[LATENCY-1] ? {r_addr[LATENCY-1], 1'b0}
                                           : {r_hold_addr, 1'b0};
`else
   assign bus.data_out  = r_vld[LATENCY-1] ? r_data[LATENCY-1] : '0;
   assign bus.data_addr = r_vld[LATENCY-1] ? {r_addr[LATENCY-1], 1'b0} : '0;
`endif

endmodule

`default_nettype wire
